// File: rtl/clock_set_ctrl_if.sv
// Key inputs, tick and counter-control outputs of the time-setting sequencer.
// Latency: none, this is wiring only.
// Backpressure: none; the strobes are single-cycle pulses the counters must take.
// Ports: tick_1hz, key_mode, key_adj go into the sequencer.
//        count_en, hour_inc, min_inc, sec_clr, mode, blink come out of it.
interface clock_set_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_adj;
    logic       count_en;
    logic       hour_inc;
    logic       min_inc;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    // master: the board/stimulus side, slave: the sequencer itself
    modport master (
        output tick_1hz, key_mode, key_adj,
        input  count_en, hour_inc, min_inc, sec_clr, mode, blink
    );
    modport slave (
        input  tick_1hz, key_mode, key_adj,
        output count_en, hour_inc, min_inc, sec_clr, mode, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: debounces MODE/ADJ, walks RUN/SET_H/SET_M/SET_S, strobes counters.
// Latency: key edge -> press event 2+DEB_CYCLES cycles; press event -> strobe/mode 1 cycle.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
// Ports: CP clock, nCR async active-low reset, io (slave) carries tick_1hz, raw keys,
//        count_en, hour_inc/min_inc/sec_clr strobes, mode and blink.
module clock_set_ctrl #(
    parameter int DEB_CYCLES    = 20000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000,
    parameter int TIMEOUT_S     = 10
) (
    input  logic           CP,
    input  logic           nCR,
    clock_set_ctrl_if.slave io
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_S + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] REP_D    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_P    = RW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning. Index 0 = MODE, index 1 = ADJ.
    // ------------------------------------------------------------------
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    assign key_raw = {io.key_adj, io.key_mode};

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int k = 0; k < 2; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] != deb[k]) begin
                    // Level flips only after DEB_CYCLES consecutive disagreeing cycles;
                    // a press event is raised on the same edge as a rising flip.
                    if (db_cnt[k] == DEB_LAST) begin
                        deb[k]    <= sync2[k];
                        press[k]  <= sync2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DW'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode sequencer
    // ------------------------------------------------------------------
    state_t        state;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] rep_cnt;
    logic          rep_act;
    logic          rep_first;

    logic mode_press;
    logic adj_press;
    logic adj_lvl;
    logic rep_fire;
    logic to_hit;

    assign mode_press = press[0];
    assign adj_press  = press[1];
    assign adj_lvl    = deb[1];

    // rep_cnt holds the number of cycles since the last strobe, so it is
    // compared directly against the delay (first repeat) or the period.
    assign rep_fire = rep_act && adj_lvl && (rep_cnt == (rep_first ? REP_D : REP_P));
    assign to_hit   = io.tick_1hz && (to_cnt == TO_LAST);
    assign io.mode  = state;

    function automatic state_t next_of(input state_t s);
        case (s)
            RUN:     next_of = SET_H;
            SET_H:   next_of = SET_M;
            SET_M:   next_of = SET_S;
            default: next_of = RUN;
        endcase
    endfunction

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state       <= RUN;
            io.count_en <= 1'b1;
            io.hour_inc <= 1'b0;
            io.min_inc  <= 1'b0;
            io.sec_clr  <= 1'b0;
            io.blink    <= 1'b0;
            to_cnt      <= '0;
            rep_cnt     <= '0;
            rep_act     <= 1'b0;
            rep_first   <= 1'b0;
        end else begin
            io.hour_inc <= 1'b0;
            io.min_inc  <= 1'b0;
            io.sec_clr  <= 1'b0;

            if (mode_press) begin
                // Mode wins over a coincident ADJ press or timeout.
                state       <= next_of(state);
                io.count_en <= (next_of(state) == RUN);
                io.blink    <= 1'b0;
                to_cnt      <= '0;
                rep_act     <= 1'b0;
            end else if (state == RUN) begin
                io.count_en <= 1'b1;
                io.blink    <= 1'b0;
                to_cnt      <= '0;
                rep_act     <= 1'b0;
            end else if (adj_press) begin
                // ADJ wins over a coincident timeout and restarts it.
                case (state)
                    SET_H:   io.hour_inc <= 1'b1;
                    SET_M:   io.min_inc  <= 1'b1;
                    default: io.sec_clr  <= 1'b1;
                endcase
                io.blink  <= 1'b0;
                to_cnt    <= '0;
                rep_act   <= (state != SET_S);
                rep_first <= 1'b1;
                rep_cnt   <= RW'(1);
            end else if (to_hit) begin
                state       <= RUN;
                io.count_en <= 1'b1;
                io.blink    <= 1'b0;
                to_cnt      <= '0;
                rep_act     <= 1'b0;
            end else begin
                if (io.tick_1hz) begin
                    to_cnt <= to_cnt + TW'(1);
                end
                if (rep_fire) begin
                    // rep_act is only ever set in SET_H / SET_M
                    if (state == SET_H) begin
                        io.hour_inc <= 1'b1;
                    end else begin
                        io.min_inc <= 1'b1;
                    end
                    io.blink  <= 1'b0;
                    rep_first <= 1'b0;
                    rep_cnt   <= RW'(1);
                end else begin
                    if (io.tick_1hz) begin
                        io.blink <= ~io.blink;
                    end
                    if (rep_act && !adj_lvl) begin
                        rep_act <= 1'b0;
                    end else if (rep_act) begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting sequencer for the digital clock. It debounces the MODE and ADJ push-buttons and walks a mode state machine: RUN, set hours, set minutes, zero seconds. It emits single-cycle increment/clear strobes to the hour/minute/second counter chain, gates normal counting, and supplies a blink flag for the display of the field being edited. It sits between the board keys and the BCD time counters (hour counter feeding the 24/12-hour display conversion).

Parameters:
DEB_CYCLES, 20000, CP cycles a synchronised key must be stable before its debounced level changes
REPEAT_DELAY, 500000, CP cycles a held ADJ key waits after its press event before auto-repeat starts
REPEAT_PERIOD, 100000, CP cycles between auto-repeat strobes
TIMEOUT_S, 10, tick_1hz pulses with no key event before a set mode falls back to RUN

Ports:
CP  input  1  system clock, all logic rising-edge
nCR  input  1  asynchronous active-low reset
tick_1hz  input  1  one-CP-cycle pulse once per second, synchronous to CP
key_mode  input  1  raw MODE button, active high, asynchronous, bouncing
key_adj  input  1  raw ADJ button, active high, asynchronous, bouncing
count_en  output  1  1 = time counters advance normally
hour_inc  output  1  one-cycle strobe: hour counter +1 (counter handles 23->00 wrap)
min_inc  output  1  one-cycle strobe: minute counter +1, no carry into hours
sec_clr  output  1  one-cycle strobe: seconds counter to 00
mode  output  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
blink  output  1  1 = blank the field selected by mode this half-period

Behaviour:
- Reset (nCR low, asynchronous): state RUN, mode=00, count_en=1, hour_inc=min_inc=sec_clr=0, blink=0. Synchronisers, debounced levels, and all counters cleared (keys treated as released). Mid-operation reset aborts any set mode and any auto-repeat immediately.
- All outputs are registered.
- Key path, per key: 2-flop synchroniser, then a stability counter (width $clog2(DEB_CYCLES+1)). The debounced level takes the synchronised value once that value has differed from it for DEB_CYCLES consecutive cycles. Any glitch back restarts the count. Press event = one-cycle pulse on the debounced rising edge. Release produces no event.
- State transitions, on mode press: RUN->SET_H->SET_M->SET_S->RUN.
- RUN: count_en=1; ADJ ignored; timeout inactive.
- SET_H / SET_M / SET_S: count_en=0.
- ADJ press in SET_H: hour_inc high the cycle after the press event. In SET_M: min_inc likewise. In SET_S: sec_clr likewise, with no auto-repeat.
- Auto-repeat (SET_H, SET_M only): while debounced ADJ stays high, the first extra strobe fires REPEAT_DELAY cycles after the press event, then one every REPEAT_PERIOD cycles. Release, a mode change, or a timeout stops it at once; no strobe on the stopping cycle.
- Timeout: counts tick_1hz pulses in set states; cleared on any press event (either key) and on every state change. When the count reaches TIMEOUT_S, next state is RUN and count_en returns to 1 the following cycle.
- Blink: 0 in RUN; cleared on entry to any set state; toggles on each tick_1hz while in a set state; forced to 0 in the cycle an inc/clr strobe is issued.
- Simultaneous events:
  - mode press + ADJ press in the same cycle: the mode press wins and the ADJ press is dropped.
  - mode press + timeout in the same cycle: the mode press wins.
  - ADJ press + timeout in the same cycle: the ADJ press is honoured and the timeout is cleared.
- Strobes are mutually exclusive and never two cycles back to back.

Test Plan:
(Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, TIMEOUT_S=3.)
- nCR low with keys toggling -> mode=00, count_en=1, all strobes 0. Release nCR, hold keys idle 50 cycles -> no change.
- key_mode bounces 1-0-1-0 at 1-cycle spacing, then held high -> exactly one press. Mode goes 00->01 at 2+4+1 cycles after the stable edge. Three further clean presses -> 10, 11, 00, with count_en 0,0,0,1.
- SET_H, single ADJ press released after 10 cycles -> exactly one hour_inc pulse, the cycle after the press event. ADJ held 52 cycles past the press event -> strobes at +1, +21, +29, +37, +45 (5 total), none after release.
- SET_S, ADJ held 60 cycles -> exactly one sec_clr pulse, no repeat, hour_inc=min_inc=0 throughout.
- SET_M, no keys, 3 tick_1hz pulses -> mode=00 after the third tick, count_en=1 next cycle. Blink sequence 0,1,0 toggling at each tick, then 0 in RUN.
- SET_M, mode and ADJ press events aligned in one cycle -> mode=11, no min_inc. Mode press coincident with the 3rd timeout tick -> mode=11, not 00.
